// File: rtl/sdram_host_arbiter_if.sv
// Host-side bundle of sdram_host_arbiter: two requester ports plus the
// sdram_controller host port. "slave" is the arbiter's view, "master" is the
// environment (requesters and controller) driving it.
interface sdram_host_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic              p0_valid;
  logic              p1_valid;
  logic              p0_we;
  logic              p1_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic [DATA_W-1:0] p1_wdata;
  logic              p0_ack;
  logic              p1_ack;
  logic              p0_rsp_valid;
  logic              p1_rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              err_timeout;
  logic [ADDR_W-1:0] ctl_addr;
  logic [DATA_W-1:0] ctl_wdata;
  logic              ctl_wr_enable;
  logic              ctl_rd_enable;
  logic              ctl_busy;
  logic              ctl_rd_ready;
  logic [DATA_W-1:0] ctl_rd_data;

  modport slave (
    input  p0_valid, p1_valid, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
    input  ctl_busy, ctl_rd_ready, ctl_rd_data,
    output p0_ack, p1_ack, p0_rsp_valid, p1_rsp_valid, rsp_data, err_timeout,
    output ctl_addr, ctl_wdata, ctl_wr_enable, ctl_rd_enable
  );

  modport master (
    output p0_valid, p1_valid, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
    output ctl_busy, ctl_rd_ready, ctl_rd_data,
    input  p0_ack, p1_ack, p0_rsp_valid, p1_rsp_valid, rsp_data, err_timeout,
    input  ctl_addr, ctl_wdata, ctl_wr_enable, ctl_rd_enable
  );
endinterface

// File: rtl/sdram_host_arbiter.sv
// sdram_host_arbiter: shares the single sdram_controller host port between two
// requesters, one transaction at a time, and routes read data to the owner.
// Optional macro SDRAM_ARB_FIXED_PRIO_EN: port 0 always wins ties (no RR pointer).
module sdram_host_arbiter #(
  parameter int ADDR_W       = 24,
  parameter int DATA_W       = 16,
  parameter int BUSY_TIMEOUT = 15
) (
  input logic                 clk,
  input logic                 rst_n,
  sdram_host_arbiter_if.slave bus
);
  localparam int              CNT_W   = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUSY_TIMEOUT);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_ctl_addr;
  logic [DATA_W-1:0] r_ctl_wdata;
  logic [DATA_W-1:0] r_rsp_data;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_grant;
  logic              w_win;
  logic              w_capture;
  logic              w_cnt_inc;
  logic              w_timeout;

  // Winner of a grant this cycle (0 = port 0, 1 = port 1)
`ifdef SDRAM_ARB_FIXED_PRIO_EN
  always_comb begin
    w_win = ~bus.p0_valid;
  end
`else
  logic r_last;

  always_comb begin
    w_win = (bus.p0_valid && bus.p1_valid) ? ~r_last : bus.p1_valid;
  end

  // Round-robin pointer: remembers the last granted port, starts at port 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_last <= 1'b1;
    else if (w_grant) r_last <= w_win;
  end
`endif

  // Next-state logic and per-state strobes
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_capture   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!bus.ctl_busy && (bus.p0_valid || bus.p1_valid)) begin
          w_grant     = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_cnt_inc   = 1'b1;
        w_state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (r_cnt == CNT_MAX) begin
          w_timeout   = 1'b1;
          w_state_nxt = IDLE;
        end else if (!r_we && bus.ctl_rd_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = RESP;
        end else if (bus.ctl_busy) begin
          w_state_nxt = WAIT_DONE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (r_we) begin
          if (!bus.ctl_busy) w_state_nxt = IDLE;
        end else if (bus.ctl_rd_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Transaction registers, latched at grant and held until the next grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner     <= 1'b0;
      r_we        <= 1'b0;
      r_ctl_addr  <= '0;
      r_ctl_wdata <= '0;
    end else if (w_grant) begin
      r_owner     <= w_win;
      r_we        <= w_win ? bus.p1_we    : bus.p0_we;
      r_ctl_addr  <= w_win ? bus.p1_addr  : bus.p0_addr;
      r_ctl_wdata <= w_win ? bus.p1_wdata : bus.p0_wdata;
    end
  end

  // Busy-wait counter: zero during the enable cycle, so it equals the number
  // of cycles elapsed since the enable; saturates at the timeout value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              r_cnt <= '0;
    else if (w_grant)                        r_cnt <= '0;
    else if (w_cnt_inc && r_cnt != CNT_MAX)  r_cnt <= r_cnt + 1'b1;
  end

  // Read data capture, held until the next read completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_rsp_data <= '0;
    else if (w_capture) r_rsp_data <= bus.ctl_rd_data;
  end

  assign bus.p0_ack        = (r_state == ISSUE) && !r_owner;
  assign bus.p1_ack        = (r_state == ISSUE) &&  r_owner;
  assign bus.ctl_wr_enable = (r_state == ISSUE) &&  r_we;
  assign bus.ctl_rd_enable = (r_state == ISSUE) && !r_we;
  assign bus.p0_rsp_valid  = (r_state == RESP)  && !r_owner;
  assign bus.p1_rsp_valid  = (r_state == RESP)  &&  r_owner;
  assign bus.err_timeout   = w_timeout;
  assign bus.ctl_addr      = r_ctl_addr;
  assign bus.ctl_wdata     = r_ctl_wdata;
  assign bus.rsp_data      = r_rsp_data;
endmodule

// File: tb/tb_sdram_host_arbiter.sv
// Directed bench for sdram_host_arbiter with a behavioural controller model
// and an ordered scoreboard of expected ack / response / timeout events.
module tb_sdram_host_arbiter;
  localparam int ADDR_W       = 24;
  localparam int DATA_W       = 16;
  localparam int BUSY_TIMEOUT = 15;
  localparam int K_ACK = 0;
  localparam int K_RSP = 1;
  localparam int K_TO  = 2;

  typedef struct {
    int                kind;
    int                port;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   en_cyc = 0;
  int   acks_seen = 0;
  int   acks_before = 0;
  ev_t  exp_q[$];

  bit                model_dead = 1'b0;
  bit                no_busy    = 1'b0;
  bit                hold_busy  = 1'b0;
  int                rd_lat     = 2;
  logic [DATA_W-1:0] model_rd   = '0;

  sdram_host_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  sdram_host_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_ev(input int kind, input int port, input logic we,
                         input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    ev_t e;
    e.kind = kind;
    e.port = port;
    e.we   = we;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic drive(input int p, input logic we,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (p == 0) begin
      bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d; bus.p0_valid = 1'b1;
    end else begin
      bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d; bus.p1_valid = 1'b1;
    end
  endtask

  task automatic wait_ack(input int p, input int limit);
    int n;
    logic a;
    n = 0;
    do begin
      tick();
      n++;
      a = (p == 0) ? bus.p0_ack : bus.p1_ack;
    end while (!a && n < limit);
    check((p == 0) ? "ack_wait_p0" : "ack_wait_p1", 32'(a), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_p0_ack"},   32'(bus.p0_ack),        '0);
    check({tag, "_p1_ack"},   32'(bus.p1_ack),        '0);
    check({tag, "_p0_rsp"},   32'(bus.p0_rsp_valid),  '0);
    check({tag, "_p1_rsp"},   32'(bus.p1_rsp_valid),  '0);
    check({tag, "_err"},      32'(bus.err_timeout),   '0);
    check({tag, "_wr_en"},    32'(bus.ctl_wr_enable), '0);
    check({tag, "_rd_en"},    32'(bus.ctl_rd_enable), '0);
    check({tag, "_ctl_addr"}, 32'(bus.ctl_addr),      '0);
    check({tag, "_ctl_wdata"},32'(bus.ctl_wdata),     '0);
    check({tag, "_rsp_data"}, 32'(bus.rsp_data),      '0);
  endtask

  // Controller model: answers an enable with busy, and for reads a
  // one-cycle rd_ready after rd_lat cycles
  initial begin
    int m_cnt;
    bit m_act;
    bit m_rd;
    m_cnt = 0; m_act = 1'b0; m_rd = 1'b0;
    bus.ctl_busy = 1'b0; bus.ctl_rd_ready = 1'b0; bus.ctl_rd_data = '0;
    forever begin
      @(negedge clk);
      bus.ctl_rd_ready = 1'b0;
      if (m_act) begin
        m_cnt++;
        if (m_rd && m_cnt == rd_lat) begin
          bus.ctl_rd_ready = 1'b1;
          bus.ctl_rd_data  = model_rd;
        end
        if (m_cnt >= (m_rd ? rd_lat + 1 : 3)) m_act = 1'b0;
      end else if (!model_dead && (bus.ctl_wr_enable || bus.ctl_rd_enable)) begin
        m_act = 1'b1; m_rd = bus.ctl_rd_enable; m_cnt = 0;
      end
      bus.ctl_busy = (m_act && !no_busy) || hold_busy;
    end
  end

  // Monitor: per-cycle invariants and in-order scoreboard of DUT events
  initial begin
    ev_t        e;
    logic [4:0] evs;
    int         k;
    forever begin
      @(negedge clk);
      check("one_enable",    32'(bus.ctl_wr_enable & bus.ctl_rd_enable), '0);
      check("enable_vs_ack", 32'(bus.ctl_wr_enable | bus.ctl_rd_enable), 32'(bus.p0_ack | bus.p1_ack));
      check("single_ack",    32'(bus.p0_ack & bus.p1_ack), '0);
      check("single_rsp",    32'(bus.p0_rsp_valid & bus.p1_rsp_valid), '0);
      evs = {bus.err_timeout, bus.p1_rsp_valid, bus.p0_rsp_valid, bus.p1_ack, bus.p0_ack};
      if (evs != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", 32'(evs), '0);
        end else begin
          e = exp_q.pop_front();
          k = (bus.p0_ack | bus.p1_ack) ? K_ACK :
              (bus.p0_rsp_valid | bus.p1_rsp_valid) ? K_RSP : K_TO;
          check("event_kind", k, e.kind);
          if (k == K_ACK) begin
            check("ack_port",      32'(bus.p1_ack),        32'(e.port));
            check("ack_wr_enable", 32'(bus.ctl_wr_enable), 32'(e.we));
            check("ack_ctl_addr",  32'(bus.ctl_addr),      32'(e.addr));
            check("ack_ctl_wdata", 32'(bus.ctl_wdata),     32'(e.data));
            en_cyc = cyc;
            acks_seen++;
          end else if (k == K_RSP) begin
            check("rsp_port", 32'(bus.p1_rsp_valid), 32'(e.port));
            check("rsp_data", 32'(bus.rsp_data),     32'(e.data));
          end else begin
            check("timeout_latency", cyc - en_cyc, BUSY_TIMEOUT);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish: CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.p0_valid = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_valid = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // p0 write, granted one cycle after sampling
    push_ev(K_ACK, 0, 1'b1, 24'hfedbed, 16'h0d05);
    drive(0, 1'b1, 24'hfedbed, 16'd3333);
    wait_ack(0, 1);
    bus.p0_valid = 1'b0;
    repeat (10) tick();

    // p1 read returning 16'hbbbb
    model_rd = 16'hbbbb;
    push_ev(K_ACK, 1, 1'b0, 24'hbedfed, 16'h0000);
    push_ev(K_RSP, 1, 1'b0, 24'h0, 16'hbbbb);
    drive(1, 1'b0, 24'hbedfed, 16'h0000);
    wait_ack(1, 1);
    bus.p1_valid = 1'b0;
    repeat (10) tick();

    // Simultaneous requests, p0 re-requesting after its first grant
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    push_ev(K_ACK, 0, 1'b1, 24'h000100, 16'haaaa);
    push_ev(K_ACK, 0, 1'b1, 24'h000300, 16'hcccc);
    push_ev(K_ACK, 1, 1'b1, 24'h000200, 16'hbbb0);
    drive(0, 1'b1, 24'h000100, 16'haaaa);
    drive(1, 1'b1, 24'h000200, 16'hbbb0);
    wait_ack(0, 1);
    drive(0, 1'b1, 24'h000300, 16'hcccc);
    wait_ack(0, 12);
    bus.p0_valid = 1'b0;
    wait_ack(1, 12);
    bus.p1_valid = 1'b0;
`else
    push_ev(K_ACK, 0, 1'b1, 24'h000100, 16'haaaa);
    push_ev(K_ACK, 1, 1'b1, 24'h000200, 16'hbbb0);
    push_ev(K_ACK, 0, 1'b1, 24'h000300, 16'hcccc);
    drive(0, 1'b1, 24'h000100, 16'haaaa);
    drive(1, 1'b1, 24'h000200, 16'hbbb0);
    wait_ack(0, 1);
    drive(0, 1'b1, 24'h000300, 16'hcccc);
    wait_ack(1, 12);
    bus.p1_valid = 1'b0;
    wait_ack(0, 12);
    bus.p0_valid = 1'b0;
`endif
    repeat (10) tick();

    // Read answered by rd_ready while still waiting for busy
    no_busy  = 1'b1;
    rd_lat   = 1;
    model_rd = 16'h1234;
    push_ev(K_ACK, 0, 1'b0, 24'h123456, 16'h0001);
    push_ev(K_RSP, 0, 1'b0, 24'h0, 16'h1234);
    drive(0, 1'b0, 24'h123456, 16'h0001);
    wait_ack(0, 1);
    bus.p0_valid = 1'b0;
    repeat (6) tick();
    no_busy = 1'b0;
    rd_lat  = 2;
    repeat (4) tick();

    // Controller never raises busy: timeout, then a new request is served
    model_dead = 1'b1;
    push_ev(K_ACK, 0, 1'b0, 24'h0000aa, 16'h0000);
    push_ev(K_TO,  0, 1'b0, 24'h0, 16'h0);
    drive(0, 1'b0, 24'h0000aa, 16'h0000);
    wait_ack(0, 1);
    bus.p0_valid = 1'b0;
    repeat (20) tick();
    model_dead = 1'b0;
    push_ev(K_ACK, 1, 1'b1, 24'h000bbb, 16'h5a5a);
    drive(1, 1'b1, 24'h000bbb, 16'h5a5a);
    wait_ack(1, 1);
    bus.p1_valid = 1'b0;
    repeat (10) tick();

    // Reset during WAIT_DONE of a read: abandoned, then a fresh read completes
    rd_lat   = 6;
    model_rd = 16'hdead;
    push_ev(K_ACK, 1, 1'b0, 24'h777777, 16'h0000);
    drive(1, 1'b0, 24'h777777, 16'h0000);
    wait_ack(1, 1);
    bus.p1_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid_read");
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
    rd_lat   = 2;
    model_rd = 16'h4321;
    push_ev(K_ACK, 1, 1'b0, 24'h00fed0, 16'h0000);
    push_ev(K_RSP, 1, 1'b0, 24'h0, 16'h4321);
    drive(1, 1'b0, 24'h00fed0, 16'h0000);
    wait_ack(1, 1);
    bus.p1_valid = 1'b0;
    repeat (10) tick();

    // Busy held by a prior op: withdrawn p1 request, p0 granted after busy falls
    hold_busy = 1'b1;
    tick();
    drive(1, 1'b1, 24'h999999, 16'h9999);
    repeat (3) tick();
    bus.p1_valid = 1'b0;
    push_ev(K_ACK, 0, 1'b1, 24'h0a0a0a, 16'h0f0f);
    drive(0, 1'b1, 24'h0a0a0a, 16'h0f0f);
    acks_before = acks_seen;
    repeat (5) tick();
    check("no_ack_while_busy", acks_seen, acks_before);
    hold_busy = 1'b0;
    tick();
    tick();
    check("ack_after_busy_low", 32'(bus.p0_ack), 32'd1);
    bus.p0_valid = 1'b0;
    repeat (10) tick();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
